param_cpu_core: RTL and testbench
=================================

Name: param_cpu_core

Overview:
- Parametrised successor of the 4-bit accumulator CPU core.
- Generic data/address width, clock-enable stepping, a HALT/RESUME state machine, and a registered output port.
- Sits between the instruction ROM (async-read, addressed by pc) and board I/O.
- Driven by the prescaled CPU clock or by the system clock with a ce strobe.

Parameters:
- DATA_W, 4, width of registers A, B, output port and immediate field (≥4).
- ADDR_W, 4, program counter width; must satisfy ADDR_W ≤ DATA_W.

Ports:
- clk_cpu  in  1  CPU clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk_cpu
- ce  in  1  clock enable; state advances only on edges with ce=1
- inst  in  4+DATA_W  instruction = {opcode[3:0], imm[DATA_W-1:0]}; must equal ROM[pc] in the same cycle
- pc  out  ADDR_W  program counter
- in_port  in  DATA_W  input port, sampled at execution
- out_port  out  DATA_W  registered output port
- carry  out  1  carry flag
- halted  out  1  high while in HALT state
- resume  in  1  leave HALT (qualified by ce)

Behaviour:
- Reset (reset_n=0 at a clk_cpu edge, regardless of ce): pc=0, A=0, B=0, out_port=0, carry=0, state=RUN, halted=0. Reset mid-HALT or mid-program is immediate on that edge.
- Two states:
  - RUN: one instruction per enabled edge.
  - HALT: all registers frozen.
- ce=0: all state holds, including in RUN.
- Opcodes (imm = inst[DATA_W-1:0]). Unless noted, pc <= pc+1 mod 2^ADDR_W:
  - 0000 ADD A,imm: {carry,A} <= A+imm, (DATA_W+1)-bit sum.
  - 0101 ADD B,imm: {carry,B} <= B+imm.
  - 0011 MOV A,imm.
  - 0111 MOV B,imm.
  - 0001 MOV A,B.
  - 0100 MOV B,A.
  - 0010 IN A: A <= in_port.
  - 0110 IN B: B <= in_port.
  - 1001 OUT B: out_port <= B.
  - 1011 OUT imm: out_port <= imm.
  - 1111 JMP: pc <= imm[ADDR_W-1:0].
  - 1110 JNC: if carry==0, pc <= imm[ADDR_W-1:0]; else pc+1.
  - 1000 HLT: state <= HALT; pc unchanged (stays on the HLT address).
  - All other opcodes: NOP.
- Carry rule: every executed non-ADD instruction (including NOP, JNC, HLT) clears carry. ADD writes it. JNC tests the carry value from before the edge.
- HALT state: resume=1 with ce=1 -> RUN and pc <= pc+1. The HLT is not re-executed and carry is held. resume is ignored in RUN.
- halted is registered; it asserts on the same edge that enters HALT.
- pc wraps from 2^ADDR_W-1 to 0 with no flag.
- Jump target bits imm[DATA_W-1:ADDR_W] are ignored.

Optional Feature:
- Macro: PARAM_CPU_CALL_EN.
- Defined: adds an ADDR_W-bit link register LR (reset 0).
  - 1010 CALL imm: LR <= pc+1, pc <= imm[ADDR_W-1:0].
  - 1100 RET: pc <= LR.
  - There is one link level only; a nested CALL overwrites LR.
  - Both instructions clear carry.
- Undefined: 1010 and 1100 are NOPs (pc+1, carry cleared) and no LR flop exists.

Test Plan:
- DATA_W=4: reset, then MOV A,0xE; ADD A,0x3 -> A=0x1, carry=1. Next instruction JNC 0x0 -> not taken, pc=3, carry=0.
- Count loop: ADD A,1; JNC 0; OUT imm 0xF; HLT, starting from A=0. Expect carry=1 when A wraps 0xF->0x0, then out_port=0xF, halted=1, pc held at the HLT address for 10 cycles. resume=1 -> pc=HLT+1, halted=0.
- ce toggled 1-in-4 -> pc/A/out_port change only on ce=1 edges; the trace matches the ce=1-always run.
- reset_n=0 while halted with out_port=0x9 -> next edge: all outputs 0, halted=0. Also drive reset_n=0 with ce=0 -> reset still applied.
- in_port=0x5: IN B; OUT B -> out_port=0x5. JMP to 0xF, then NOP at 0xF -> pc wraps to 0x0.
- With PARAM_CPU_CALL_EN: CALL 0x8 from pc=2 -> pc=8, LR=3; RET -> pc=3. Without the macro: same program treats 1010 as NOP -> pc=3 immediately.

Source files
------------

// File: rtl/param_cpu_core.sv
// param_cpu_core: parametrised accumulator CPU core.
//
// Two data registers (A, B), a carry flag, a registered output port and a
// RUN/HALT state machine. One instruction executes per clk_cpu edge with ce=1
// while in RUN. Instructions come from an async-read ROM addressed by pc.
// The instruction word is {opcode[3:0], imm[DATA_W-1:0]}.
//
// Optional feature: define PARAM_CPU_CALL_EN to add a single-level link
// register with CALL (1010) and RET (1100). Without the macro those two
// opcodes behave as NOPs and no link register is built.
//
// Parameter constraints: DATA_W >= 4 and ADDR_W <= DATA_W.

module param_cpu_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk_cpu,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [DATA_W+3:0]   inst,
    output logic [ADDR_W-1:0]   pc,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                carry,
    output logic                halted,
    input  logic                resume
);

    // Run/halt state encoding; kept as one bit so halted is the flop itself.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Opcode map.
    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_HLT    = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;
`ifdef PARAM_CPU_CALL_EN
    localparam logic [3:0] OP_CALL   = 4'b1010;
    localparam logic [3:0] OP_RET    = 4'b1100;
`endif

    // Architectural state.
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] out_r;
    logic              carry_r;
    logic [0:0]        state_r;
`ifdef PARAM_CPU_CALL_EN
    logic [ADDR_W-1:0] lr_r;
    logic [ADDR_W-1:0] lr_nxt_s;
`endif

    // Next-state values computed by the decoder.
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [DATA_W-1:0] a_nxt_s;
    logic [DATA_W-1:0] b_nxt_s;
    logic [DATA_W-1:0] out_nxt_s;
    logic              carry_nxt_s;
    logic [0:0]        state_nxt_s;

    // Instruction fields and shared arithmetic.
    logic [3:0]        opcode_s;
    logic [DATA_W-1:0] imm_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] jmp_tgt_s;
    logic [DATA_W:0]   sum_a_s;
    logic [DATA_W:0]   sum_b_s;

    assign opcode_s  = inst[DATA_W+3:DATA_W];
    assign imm_s     = inst[DATA_W-1:0];
    // pc wraps naturally at 2^ADDR_W; no overflow flag is kept.
    assign pc_inc_s  = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    // Immediate bits above ADDR_W are ignored for jump targets.
    assign jmp_tgt_s = imm_s[ADDR_W-1:0];
    // Sums are one bit wider so the top bit becomes the carry.
    assign sum_a_s   = {1'b0, a_r} + {1'b0, imm_s};
    assign sum_b_s   = {1'b0, b_r} + {1'b0, imm_s};

    // Decode the current instruction (RUN) or the resume request (HALT).
    always_comb begin
        pc_nxt_s    = pc_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        out_nxt_s   = out_r;
        carry_nxt_s = carry_r;
        state_nxt_s = state_r;
`ifdef PARAM_CPU_CALL_EN
        lr_nxt_s    = lr_r;
`endif
        if (state_r == ST_RUN) begin
            // Every executed instruction advances pc and clears carry
            // unless its case below says otherwise.
            pc_nxt_s    = pc_inc_s;
            carry_nxt_s = 1'b0;
            case (opcode_s)
                OP_ADD_A:  {carry_nxt_s, a_nxt_s} = sum_a_s;
                OP_ADD_B:  {carry_nxt_s, b_nxt_s} = sum_b_s;
                OP_MOV_A:  a_nxt_s   = imm_s;
                OP_MOV_B:  b_nxt_s   = imm_s;
                OP_MOV_AB: a_nxt_s   = b_r;
                OP_MOV_BA: b_nxt_s   = a_r;
                OP_IN_A:   a_nxt_s   = in_port;
                OP_IN_B:   b_nxt_s   = in_port;
                OP_OUT_B:  out_nxt_s = b_r;
                OP_OUT_I:  out_nxt_s = imm_s;
                OP_JMP:    pc_nxt_s  = jmp_tgt_s;
                OP_JNC: begin
                    // Tests the carry produced by the previous instruction.
                    if (carry_r == 1'b0) begin
                        pc_nxt_s = jmp_tgt_s;
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
                end
                OP_HLT: begin
                    // pc stays on the HLT so resume continues after it.
                    pc_nxt_s    = pc_r;
                    state_nxt_s = ST_HALT;
                end
`ifdef PARAM_CPU_CALL_EN
                OP_CALL: begin
                    // Single link level: a nested CALL overwrites LR.
                    lr_nxt_s = pc_inc_s;
                    pc_nxt_s = jmp_tgt_s;
                end
                OP_RET:    pc_nxt_s  = lr_r;
`endif
                default: begin
                    // Undefined opcodes are NOPs.
                    pc_nxt_s = pc_inc_s;
                end
            endcase
        end else begin
            // HALT: everything frozen (carry included) until resume.
            if (resume) begin
                state_nxt_s = ST_RUN;
                pc_nxt_s    = pc_inc_s;
            end else begin
                state_nxt_s = ST_HALT;
            end
        end
    end

    // State registers: synchronous reset wins over ce; otherwise update on ce.
    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            pc_r    <= {ADDR_W{1'b0}};
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            out_r   <= {DATA_W{1'b0}};
            carry_r <= 1'b0;
            state_r <= ST_RUN;
        end else if (ce) begin
            pc_r    <= pc_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            out_r   <= out_nxt_s;
            carry_r <= carry_nxt_s;
            state_r <= state_nxt_s;
        end else begin
            pc_r    <= pc_r;
            a_r     <= a_r;
            b_r     <= b_r;
            out_r   <= out_r;
            carry_r <= carry_r;
            state_r <= state_r;
        end
    end

`ifdef PARAM_CPU_CALL_EN
    // Link register for CALL/RET, same reset and enable rules as the core.
    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            lr_r <= {ADDR_W{1'b0}};
        end else if (ce) begin
            lr_r <= lr_nxt_s;
        end else begin
            lr_r <= lr_r;
        end
    end
`endif

    // All outputs come straight from flops.
    assign pc       = pc_r;
    assign out_port = out_r;
    assign carry    = carry_r;
    assign halted   = (state_r == ST_HALT);

endmodule

// File: tb/tb_param_cpu_core.sv
// Self-checking bench for param_cpu_core (DATA_W=4, ADDR_W=4).
// An instruction-level model executes the same ROM image and is compared
// with the DUT outputs on every falling edge; directed programs add
// hand-computed literal expectations. Honours PARAM_CPU_CALL_EN.

module tb_param_cpu_core;

    localparam int DW   = 4;
    localparam int AW   = 4;
    localparam int DMOD = 1 << DW;
    localparam int PMOD = 1 << AW;

    logic          clk_cpu = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce      = 1'b1;
    logic [DW+3:0] inst;
    logic [AW-1:0] pc;
    logic [DW-1:0] in_port = 4'h0;
    logic [DW-1:0] out_port;
    logic          carry;
    logic          halted;
    logic          resume  = 1'b0;

    logic [DW+3:0] rom [0:PMOD-1];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model state.
    int m_pc, m_a, m_b, m_out, m_carry, m_halt, m_lr;

    param_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_cpu (clk_cpu),
        .reset_n (reset_n),
        .ce      (ce),
        .inst    (inst),
        .pc      (pc),
        .in_port (in_port),
        .out_port(out_port),
        .carry   (carry),
        .halted  (halted),
        .resume  (resume)
    );

    // Asynchronous ROM addressed by the DUT program counter.
    assign inst = rom[pc];

    always #5 clk_cpu = ~clk_cpu;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Instruction-level reference model, one step per rising edge.
    always @(posedge clk_cpu) begin
        int op, imm, nxt, c, sum;
        if (!reset_n) begin
            m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_carry = 0; m_halt = 0; m_lr = 0;
        end else if (ce) begin
            if (m_halt != 0) begin
                if (resume) begin
                    m_halt = 0;
                    m_pc   = (m_pc + 1) % PMOD;
                end
            end else begin
                op  = int'(rom[m_pc]) / DMOD;
                imm = int'(rom[m_pc]) % DMOD;
                nxt = (m_pc + 1) % PMOD;
                c   = 0;
                case (op)
                    0:  begin sum = m_a + imm; m_a = sum % DMOD; c = sum / DMOD; end
                    5:  begin sum = m_b + imm; m_b = sum % DMOD; c = sum / DMOD; end
                    3:  m_a = imm;
                    7:  m_b = imm;
                    1:  m_a = m_b;
                    4:  m_b = m_a;
                    2:  m_a = int'(in_port);
                    6:  m_b = int'(in_port);
                    9:  m_out = m_b;
                    11: m_out = imm;
                    15: nxt = imm % PMOD;
                    14: if (m_carry == 0) nxt = imm % PMOD;
                    8:  begin nxt = m_pc; m_halt = 1; end
`ifdef PARAM_CPU_CALL_EN
                    10: begin m_lr = (m_pc + 1) % PMOD; nxt = imm % PMOD; end
                    12: nxt = m_lr;
`endif
                    default: ;
                endcase
                m_carry = c;
                m_pc    = nxt;
            end
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk_cpu) begin
        if (chk_en) begin
            check("pc",       int'(pc),       m_pc);
            check("out_port", int'(out_port), m_out);
            check("carry",    int'(carry),    m_carry);
            check("halted",   int'(halted),   m_halt);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_cpu);
            #1;
        end
    endtask

    // Reset, load a fresh ROM image (unset words are HLT), release reset.
    task automatic start_prog(input logic [DW+3:0] img [0:PMOD-1]);
        reset_n = 1'b0;
        ce      = 1'b1;
        resume  = 1'b0;
        for (int i = 0; i < PMOD; i++) rom[i] = img[i];
        tick(2);
        check("rst_pc",     int'(pc),       0);
        check("rst_out",    int'(out_port), 0);
        check("rst_halted", int'(halted),   0);
        reset_n = 1'b1;
    endtask

    logic [DW+3:0] img [0:PMOD-1];

    task automatic clear_img();
        for (int i = 0; i < PMOD; i++) img[i] = 8'h80;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Program 1: MOV A,E; ADD A,3; JNC 0; MOV B,A; OUT B; HLT.
        clear_img();
        img[0] = 8'h3E; img[1] = 8'h03; img[2] = 8'hE0;
        img[3] = 8'h40; img[4] = 8'h90; img[5] = 8'h80;
        start_prog(img);
        chk_en = 1'b1;
        tick(2);
        check("p1_add_carry", int'(carry), 1);
        check("p1_add_pc",    int'(pc),    2);
        tick(1);
        check("p1_jnc_pc",    int'(pc),    3);
        check("p1_jnc_carry", int'(carry), 0);
        tick(2);
        check("p1_out_a",     int'(out_port), 1);
        resume = 1'b1;   // ignored in RUN
        tick(1);
        resume = 1'b0;
        check("p1_halted",    int'(halted), 1);
        check("p1_hlt_pc",    int'(pc),     5);

        // Program 2: count loop ADD A,1; JNC 0; OUT F; HLT.
        clear_img();
        img[0] = 8'h01; img[1] = 8'hE0; img[2] = 8'hBF; img[3] = 8'h80;
        start_prog(img);
        tick(31);
        check("p2_wrap_carry", int'(carry), 1);
        check("p2_wrap_pc",    int'(pc),    1);
        tick(3);
        check("p2_out",    int'(out_port), 15);
        check("p2_halted", int'(halted),   1);
        tick(10);
        check("p2_hold_pc", int'(pc), 3);
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        check("p2_resume_pc",     int'(pc),     4);
        check("p2_resume_halted", int'(halted), 0);
        tick(2);

        // Program 2 again with ce asserted on one edge in four.
        start_prog(img);
        for (int i = 0; i < 136; i++) begin
            ce = (i % 4 == 0);
            tick(1);
            if (i == 3) check("ce_hold_pc", int'(pc), 1);
        end
        ce = 1'b1;
        check("ce_out",    int'(out_port), 15);
        check("ce_halted", int'(halted),   1);
        check("ce_pc",     int'(pc),       3);

        // Program 3: OUT 9; HLT, then reset while halted (with and without ce).
        clear_img();
        img[0] = 8'hB9; img[1] = 8'h80;
        start_prog(img);
        tick(2);
        check("p3_out9",   int'(out_port), 9);
        check("p3_halted", int'(halted),   1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("p3_rst_out",    int'(out_port), 0);
        check("p3_rst_halted", int'(halted),   0);
        tick(2);
        ce = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("p3_rstce_out",    int'(out_port), 0);
        check("p3_rstce_halted", int'(halted),   0);
        check("p3_rstce_pc",     int'(pc),       0);
        ce = 1'b1;
        tick(1);

        // Program 4: IN B; OUT B; JMP F; NOP at F wraps pc to 0.
        clear_img();
        img[0] = 8'h60; img[1] = 8'h90; img[2] = 8'hFF; img[15] = 8'hD0;
        start_prog(img);
        in_port = 4'h5;
        tick(2);
        check("p4_out5", int'(out_port), 5);
        tick(1);
        check("p4_jmp_pc", int'(pc), 15);
        tick(1);
        check("p4_wrap_pc", int'(pc), 0);
        in_port = 4'hA;
        tick(2);
        check("p4_outA", int'(out_port), 10);

        // Program 5: ADD B carry, MOV A,B, ADD A wrap, JNC not taken.
        clear_img();
        img[0] = 8'h7F; img[1] = 8'h52; img[2] = 8'h90; img[3] = 8'h10;
        img[4] = 8'h0F; img[5] = 8'hE0; img[6] = 8'h40; img[7] = 8'h90;
        start_prog(img);
        tick(2);
        check("p5_addb_carry", int'(carry), 1);
        tick(1);
        check("p5_outb", int'(out_port), 1);
        check("p5_out_carry", int'(carry), 0);
        tick(2);
        check("p5_adda_carry", int'(carry), 1);
        tick(1);
        check("p5_jnc_pc", int'(pc), 6);
        tick(3);
        check("p5_out0",    int'(out_port), 0);
        check("p5_halted",  int'(halted),   1);

        // Program 6: NOP; NOP; CALL 8; (8) RET.
        clear_img();
        img[0] = 8'hD0; img[1] = 8'hD0; img[2] = 8'hA8; img[8] = 8'hC0;
        start_prog(img);
        tick(3);
`ifdef PARAM_CPU_CALL_EN
        check("p6_call_pc", int'(pc), 8);
        tick(1);
        check("p6_ret_pc",  int'(pc), 3);
        tick(1);
        check("p6_halted",  int'(halted), 1);
`else
        check("p6_nop_pc",  int'(pc), 3);
        tick(1);
        check("p6_halted",  int'(halted), 1);
`endif
        tick(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
